// File: rtl/popcount_seq.sv
// rtl/popcount_seq.sv - sequential popcount of a wide word, one chunk per cycle
module popcount_seq #(
  parameter  int DATA_WIDTH = 16,
  parameter  int CHUNKS     = 4,
  localparam int CW         = $clog2(DATA_WIDTH*CHUNKS) + 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clr,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_WIDTH*CHUNKS-1:0] in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [CW-1:0]                out_count,
  output logic                         busy
);

  localparam int IW = $clog2(CHUNKS);

  typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

  state_t                        state_q, state_d;
  logic [DATA_WIDTH*CHUNKS-1:0]  data_q;
  logic [CW-1:0]                 acc_q;
  logic [IW-1:0]                 idx_q;
  logic [CW-1:0]                 pc;
  logic [CW-1:0]                 sum;
  logic                          accept;
  logic                          last;

  assign in_ready  = (state_q == IDLE) && rst_n;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign accept    = in_valid && in_ready && !clr;
  assign last      = (idx_q == IW'(CHUNKS-1));
  assign sum       = acc_q + pc;

  // The captured word shifts down each cycle, so the low chunk is always chunk[idx].
  always_comb begin
    pc = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      pc = pc + CW'(data_q[i]);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = COUNT;
      COUNT:   if (last) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (clr) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q    <= '0;
      acc_q     <= '0;
      idx_q     <= '0;
      out_count <= '0;
    end else if (clr) begin
      acc_q <= '0;
      idx_q <= '0;
    end else if (accept) begin
      data_q <= in_data;
      acc_q  <= '0;
      idx_q  <= '0;
    end else if (state_q == COUNT) begin
      data_q <= data_q >> DATA_WIDTH;
      acc_q  <= sum;
      idx_q  <= idx_q + 1'b1;
      if (last) out_count <= sum;
    end
  end

endmodule

// File: tb/tb_popcount_seq.sv
// tb/tb_popcount_seq.sv - directed-vector bench for popcount_seq
module tb_popcount_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [6:0]  out_count;
  logic        busy;

  int   n_cmp = 0;
  int   n_bad = 0;
  logic seen;

  popcount_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_count (out_count),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one word in IDLE; afterwards the input bus is scrambled to prove it was captured.
  task automatic send(input logic [63:0] d);
    in_data  = d;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    in_data  = 64'hDEAD_BEEF_1234_5678;
  endtask

  task automatic wait_out(input string tag, input logic [6:0] exp);
    int lat;
    lat = 0;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    check({tag, "_lat"}, 64'(lat), 64'd4);
    check({tag, "_cnt"}, 64'(out_count), 64'(exp));
  endtask

  task automatic drain(input string tag, input logic [6:0] exp);
    step();
    check({tag, "_ov_low"}, 64'(out_valid), 64'd0);
    check({tag, "_in_rdy"}, 64'(in_ready), 64'd1);
    check({tag, "_keep"}, 64'(out_count), 64'(exp));
  endtask

  task automatic watch_quiet(input string tag);
    seen = 1'b0;
    repeat (6) begin
      step();
      seen |= out_valid;
    end
    check(tag, 64'(seen), 64'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    clr       = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    repeat (2) step();
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_out_count", 64'(out_count), 64'd0);
    rst_n = 1'b1;
    step();
    check("rel_in_ready", 64'(in_ready), 64'd1);

    send(64'hFFFF_FFFF_FFFF_FFFF);
    wait_out("ones", 7'd64);
    drain("ones", 7'd64);

    send(64'h000F_0007_0003_0001);
    wait_out("mix", 7'd10);
    drain("mix", 7'd10);

    send(64'h0);
    wait_out("zero", 7'd0);
    drain("zero", 7'd0);

    // Consumer stalls while a new word is already being offered.
    out_ready = 1'b0;
    send(64'h0000_0000_0000_00FF);
    wait_out("hold", 7'd8);
    in_valid = 1'b1;
    in_data  = 64'h1;
    repeat (5) begin
      step();
      check("hold_ov", 64'(out_valid), 64'd1);
      check("hold_cnt", 64'(out_count), 64'd8);
      check("hold_in_rdy", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    step();
    check("hold_hs_ov", 64'(out_valid), 64'd0);
    check("hold_hs_rdy", 64'(in_ready), 64'd1);
    check("hold_hs_busy", 64'(busy), 64'd0);
    in_valid = 1'b0;
    step();
    check("hold_no_accept", 64'(busy), 64'd0);

    send(64'hFFFF_0000_FFFF_0000);
    wait_out("b2b_a", 7'd32);
    drain("b2b_a", 7'd32);
    send(64'h8000_0000_0000_0001);
    wait_out("b2b_b", 7'd2);
    drain("b2b_b", 7'd2);

    send(64'hFFFF_FFFF_FFFF_FFFF);
    step();
    step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("clr_busy", 64'(busy), 64'd0);
    check("clr_ov", 64'(out_valid), 64'd0);
    check("clr_cnt_kept", 64'(out_count), 64'd2);
    watch_quiet("clr_no_ov");
    send(64'h1);
    wait_out("after_clr", 7'd1);
    drain("after_clr", 7'd1);

    // clr wins over an offered word.
    in_data  = 64'hFF;
    in_valid = 1'b1;
    clr      = 1'b1;
    step();
    clr      = 1'b0;
    in_valid = 1'b0;
    check("clr_prio_busy", 64'(busy), 64'd0);

    send(64'hFFFF_FFFF_FFFF_FFFF);
    step();
    step();
    rst_n = 1'b0;
    #1;
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_in_rdy", 64'(in_ready), 64'd0);
    check("arst_cnt", 64'(out_count), 64'd0);
    step();
    rst_n = 1'b1;
    watch_quiet("arst_no_ov");
    send(64'h1);
    wait_out("after_rst", 7'd1);
    drain("after_rst", 7'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
